tcdm_copy_initiator: RTL and testbench

- TCDM initiator (master) engine: drives one TCDM port with the same req/gnt/r_valid protocol that the memory models answer.
- COPY mode moves a block of words from src to dst through an internal FIFO. FILL mode writes an incrementing pattern.
- Used in Verilator benches next to the RedMulE wrapper to preload or stress data memories and to check them, with no core in the loop.
- A 32-bit checksum of all data moved is exposed for self-checking.

---
 rtl/tcdm_copy_initiator.sv | 253 +++++++++++++++++++++++++
 tb/tb_tcdm_copy_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_copy_initiator.sv
// rtl/tcdm_copy_initiator.sv - TCDM initiator engine for COPY/FILL block transfers with running checksum
//
// Drives one TCDM port (req/gnt/r_valid). COPY reads len words from src and
// writes them to dst through a small read-data FIFO. FILL writes pattern+i to
// dst. The checksum is the modulo-2^32 sum of all data moved.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, mode_i               start pulse (IDLE only), 0 = COPY, 1 = FILL
//   src_addr_i, dst_addr_i        byte addresses (bits [1:0] ignored)
//   len_i, pattern_i              length in words, FILL base value
//   busy_o, done_o, err_o         status; err_o is sticky until the next start
//   checksum_o                    running sum of moved data
//   tcdm_req_o .. tcdm_data_o     registered request channel
//   tcdm_gnt_i, tcdm_r_data_i,
//   tcdm_r_valid_i                grant and in-order read response

module tcdm_copy_initiator #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      pattern_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      checksum_o,
    output logic             tcdm_req_o,
    output logic [31:0]      tcdm_add_o,
    output logic             tcdm_wen_o,
    output logic [3:0]       tcdm_be_o,
    output logic [31:0]      tcdm_data_o,
    input  logic             tcdm_gnt_i,
    input  logic [31:0]      tcdm_r_data_i,
    input  logic             tcdm_r_valid_i
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      rd_addr_q, rd_addr_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      fill_q, fill_d;
    logic [LEN_W-1:0] rd_issued_q, rd_issued_d;
    logic [LEN_W-1:0] wr_issued_q, wr_issued_d;
    logic [LEN_W-1:0] wr_granted_q, wr_granted_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [31:0]      checksum_q, checksum_d;
    logic             err_q, err_d;
    logic             req_q, req_d;
    logic [31:0]      add_q, add_d;
    logic             wen_q, wen_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;

    logic [31:0]      fifo_mem [FIFO_DEPTH];

    logic             accept, launch;
    logic             wr_fire, rd_fire, rv_ok, rv_bad, push, pop;
    logic             fin_cond, can_issue;
    logic [CNT_W-1:0] fcnt_left;
    logic [CNT_W:0]   occ_n;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        len_d        = len_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        fill_d       = fill_q;
        rd_issued_d  = rd_issued_q;
        wr_issued_d  = wr_issued_q;
        checksum_d   = checksum_q;
        err_d        = err_q;
        req_d        = req_q;
        add_d        = add_q;
        wen_d        = wen_q;
        data_d       = data_q;

        accept  = (state_q == S_IDLE) && start_i;
        launch  = accept && (len_i != '0);
        wr_fire = req_q && tcdm_gnt_i && !wen_q;
        rd_fire = req_q && tcdm_gnt_i && wen_q;
        rv_ok   = tcdm_r_valid_i && (outst_q != '0);
        rv_bad  = tcdm_r_valid_i && (outst_q == '0);
        push    = rv_ok;
        // A write leaves the FIFO only when granted, so the head stays put
        // (and data_q stays valid) while the request is stalled.
        pop     = wr_fire && !mode_q;

        outst_d      = outst_q + CNT_W'(rd_fire) - CNT_W'(rv_ok);
        fcnt_d       = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        wptr_d       = wptr_q + PTR_W'(push);
        rptr_d       = rptr_q + PTR_W'(pop);
        wr_granted_d = wr_granted_q + LEN_W'(wr_fire);

        if (accept) begin
            checksum_d = '0;
        end else if (rv_ok) begin
            checksum_d = checksum_q + tcdm_r_data_i;
        end else if (wr_fire && mode_q) begin
            checksum_d = checksum_q + data_q;
        end

        if (accept) begin
            err_d = rv_bad;
        end else if (rv_bad) begin
            err_d = 1'b1;
        end

        fin_cond = (state_q == S_RUN) && (wr_granted_d == len_q) && (outst_d == '0);

        case (state_q)
            S_IDLE:  if (accept) state_d = launch ? S_RUN : S_FIN;
            S_RUN:   if (fin_cond) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // On launch the first operation is chosen from the inputs directly so
        // that req rises in the cycle right after start.
        if (launch) begin
            mode_d       = mode_i;
            len_d        = len_i;
            rd_addr_d    = {src_addr_i[31:2], 2'b00};
            wr_addr_d    = {dst_addr_i[31:2], 2'b00};
            fill_d       = pattern_i;
            rd_issued_d  = '0;
            wr_issued_d  = '0;
            wr_granted_d = '0;
        end

        if (req_q && tcdm_gnt_i) begin
            req_d = 1'b0;
        end

        can_issue = (launch || ((state_q == S_RUN) && !fin_cond)) && (!req_q || tcdm_gnt_i);
        fcnt_left = fcnt_q - CNT_W'(pop);
        occ_n     = {1'b0, outst_d} + {1'b0, fcnt_d};

        if (can_issue) begin
            if (!mode_d) begin
                if (fcnt_left != '0) begin
                    req_d       = 1'b1;
                    wen_d       = 1'b0;
                    add_d       = wr_addr_d;
                    data_d      = fifo_mem[rptr_d];
                    wr_addr_d   = wr_addr_d + 32'd4;
                    wr_issued_d = wr_issued_d + LEN_W'(1);
                end else if ((rd_issued_d < len_d) && (occ_n < DEPTH_C)) begin
                    req_d       = 1'b1;
                    wen_d       = 1'b1;
                    add_d       = rd_addr_d;
                    rd_addr_d   = rd_addr_d + 32'd4;
                    rd_issued_d = rd_issued_d + LEN_W'(1);
                end
            end else if (wr_issued_d < len_d) begin
                req_d       = 1'b1;
                wen_d       = 1'b0;
                add_d       = wr_addr_d;
                data_d      = fill_d;
                fill_d      = fill_d + 32'd1;
                wr_addr_d   = wr_addr_d + 32'd4;
                wr_issued_d = wr_issued_d + LEN_W'(1);
            end
        end

        be_d = req_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            len_q        <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            fill_q       <= '0;
            rd_issued_q  <= '0;
            wr_issued_q  <= '0;
            wr_granted_q <= '0;
            outst_q      <= '0;
            fcnt_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            checksum_q   <= '0;
            err_q        <= 1'b0;
            req_q        <= 1'b0;
            add_q        <= '0;
            wen_q        <= 1'b0;
            data_q       <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            len_q        <= len_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            fill_q       <= fill_d;
            rd_issued_q  <= rd_issued_d;
            wr_issued_q  <= wr_issued_d;
            wr_granted_q <= wr_granted_d;
            outst_q      <= outst_d;
            fcnt_q       <= fcnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            checksum_q   <= checksum_d;
            err_q        <= err_d;
            req_q        <= req_d;
            add_q        <= add_d;
            wen_q        <= wen_d;
            data_q       <= data_d;
            be_q         <= be_d;
        end
    end

    // Storage only; emptiness is tracked by fcnt_q, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wptr_q] <= tcdm_r_data_i;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FIN);
    assign err_o       = err_q;
    assign checksum_o  = checksum_q;
    assign tcdm_req_o  = req_q;
    assign tcdm_add_o  = add_q;
    assign tcdm_wen_o  = wen_q;
    assign tcdm_be_o   = be_q;
    assign tcdm_data_o = data_q;

endmodule

// File: tb/tb_tcdm_copy_initiator.sv
// tb/tb_tcdm_copy_initiator.sv - scoreboard bench for tcdm_copy_initiator with memory responder model

module tb_tcdm_copy_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode;
    logic [31:0] src, dst, pattern;
    logic [15:0] len;
    logic        busy, done, err;
    logic [31:0] checksum;
    logic        req, wen;
    logic [31:0] add, wdata;
    logic [3:0]  be;
    logic        gnt, rv;
    logic [31:0] rdata;

    tcdm_copy_initiator dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .mode_i         (mode),
        .src_addr_i     (src),
        .dst_addr_i     (dst),
        .len_i          (len),
        .pattern_i      (pattern),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .checksum_o     (checksum),
        .tcdm_req_o     (req),
        .tcdm_add_o     (add),
        .tcdm_wen_o     (wen),
        .tcdm_be_o      (be),
        .tcdm_data_o    (wdata),
        .tcdm_gnt_i     (gnt),
        .tcdm_r_data_i  (rdata),
        .tcdm_r_valid_i (rv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] data; int due; } rsp_t;

    wr_t         exp_q[$];
    logic [31:0] exp_sum;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // stimulus-owned controls
    bit gnt_rand = 0;
    bit lat_rand = 0;
    int spur_cnt = 0;
    int xfer_id = 0;
    int cyc0 = 0;

    // responder: grant and memory effect follow the handshake seen at the previous negedge
    int   spur_ack = 0;
    rsp_t rsp_q[$];
    initial begin
        logic        hs, hs_wen;
        logic [31:0] hs_add, hs_data;
        rsp_t        r;
        gnt = 1'b0; rv = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            hs = rst_n && req && gnt; hs_wen = wen; hs_add = add; hs_data = wdata;
            @(posedge clk); #1;
            if (!rst_n) begin
                rsp_q.delete(); gnt = 1'b0; rv = 1'b0;
                spur_ack = spur_cnt;
            end else begin
                if (hs) begin
                    if (hs_wen) begin
                        r.data = mem_rd(hs_add);
                        r.due  = cyc + (lat_rand ? int'($urandom_range(0, 2)) : 0);
                        rsp_q.push_back(r);
                    end else begin
                        mem[hs_add] = hs_data;
                    end
                end
                rv = 1'b0;
                if (spur_ack != spur_cnt) begin
                    rv = 1'b1; rdata = $urandom; spur_ack = spur_cnt;
                end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    r = rsp_q.pop_front();
                    rv = 1'b1; rdata = r.data;
                end
                gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // monitor: checks writes against the scoreboard and collects per-transfer statistics
    int          seen_id = 0;
    int          rd_cnt = 0, wr_cnt = 0, max_occ = 0, stab_err = 0, req_seen = 0, be_err = 0;
    int          first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic [31:0] done_sum = '0;
    logic        busy_after_done = 1'b1;
    logic        prev_done = 1'b0, prev_pend = 1'b0, p_wen = 1'b0;
    logic [31:0] p_add = '0, p_data = '0;
    always @(negedge clk) begin
        wr_t w;
        if (seen_id != xfer_id) begin
            seen_id = xfer_id;
            rd_cnt = 0; wr_cnt = 0; max_occ = 0; stab_err = 0; req_seen = 0; be_err = 0;
            first_wr_cyc = 0; last_wr_cyc = 0; busy_after_done = 1'b1;
        end
        if (!rst_n) begin
            prev_pend = 1'b0; prev_done = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_done) busy_after_done = busy;
            prev_done = done;
            if (prev_pend && (!req || add != p_add || wen != p_wen || wdata != p_data)) stab_err++;
            prev_pend = req && !gnt; p_add = add; p_wen = wen; p_data = wdata;
            if (req) begin
                req_seen++;
                if (be != 4'hF) be_err++;
            end
            if (req && gnt) begin
                if (wen) begin
                    rd_cnt++;
                end else begin
                    if (wr_cnt == 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write addr=%h data=%h", add, wdata);
                    end else begin
                        w = exp_q.pop_front();
                        chk("wr_addr", add, w.addr);
                        chk("wr_data", wdata, w.data);
                    end
                end
                if (rd_cnt - wr_cnt > max_occ) max_occ = rd_cnt - wr_cnt;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; done_sum = checksum;
                chk("done_checksum", checksum, exp_sum);
                chk("done_writes_left", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    // expected writes come from the transfer rules: write i -> dst+4i with pattern+i or src word i
    task automatic do_start(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input logic [31:0] p);
        wr_t w;
        exp_q.delete();
        exp_sum = '0;
        for (int i = 0; i < int'(l); i++) begin
            w.addr = {d[31:2], 2'b00} + 32'(i) * 32'd4;
            w.data = m ? p + 32'(i) : mem_rd({s[31:2], 2'b00} + 32'(i) * 32'd4);
            exp_q.push_back(w);
            exp_sum += w.data;
        end
        xfer_id++;
        @(posedge clk); #1;
        start = 1'b1; mode = m; src = s; dst = d; len = l; pattern = p;
        cyc0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int max_cyc);
        int n = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL %s done_timeout after %0d cycles", name, max_cyc);
        end
        repeat (3) @(negedge clk);
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_stable"}, 32'(stab_err), 32'd0);
        chk({name, "_be"}, 32'(be_err), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          d0;
        logic [31:0] s, d, sum0;
        logic        m;
        logic [15:0] l;
        int          n;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; pattern = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_add", add, 0);
        chk("rst_wen", 32'(wen), 0);
        chk("rst_be", 32'(be), 0);
        chk("rst_data", wdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // FILL len=4, cycle-exact
        d0 = done_cnt;
        do_start(1'b1, 32'h0, 32'h0011_0000, 16'd4, 32'h10);
        wait_done("fill4", d0, 100);
        chk("fill4_sum", done_sum, 32'h46);
        chk("fill4_first_cyc", 32'(first_wr_cyc - cyc0), 32'd1);
        chk("fill4_last_cyc", 32'(last_wr_cyc - cyc0), 32'd4);
        chk("fill4_done_cyc", 32'(done_cyc - cyc0), 32'd5);
        chk("fill4_idle_after_done", 32'(busy_after_done), 32'd0);
        chk("fill4_mem0", mem_rd(32'h0011_0000), 32'h10);
        chk("fill4_mem3", mem_rd(32'h0011_000C), 32'h13);

        // COPY len=8, 1-cycle latency
        for (int i = 0; i < 8; i++) mem[32'h0011_0000 + 32'(i) * 4] = 32'(i + 1);
        d0 = done_cnt;
        do_start(1'b0, 32'h0011_0000, 32'h0011_0100, 16'd8, 32'h0);
        wait_done("copy8", d0, 200);
        chk("copy8_sum", done_sum, 32'h24);
        chk("copy8_occ_le_depth", 32'(max_occ <= 4), 32'd1);
        for (int i = 0; i < 8; i++) chk("copy8_dst", mem_rd(32'h0011_0100 + 32'(i) * 4), 32'(i + 1));

        // COPY len=16 with random grant and latency, plus an ignored start while busy
        gnt_rand = 1; lat_rand = 1;
        for (int i = 0; i < 16; i++) mem[32'h0012_0000 + 32'(i) * 4] = $urandom;
        d0 = done_cnt;
        do_start(1'b0, 32'h0012_0000, 32'h0013_0000, 16'd16, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        chk("restart_busy", 32'(busy), 32'd1);
        start = 1'b1; mode = 1'b1; dst = 32'h0014_0000; len = 16'd5; pattern = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("copy16", d0, 2000);
        chk("copy16_occ_le_depth", 32'(max_occ <= 4), 32'd1);
        chk("copy16_writes", 32'(wr_cnt), 32'd16);

        // len=0
        gnt_rand = 0; lat_rand = 0;
        d0 = done_cnt;
        do_start(1'b0, 32'h0012_0000, 32'h0015_0000, 16'd0, 32'h0);
        wait_done("len0", d0, 20);
        chk("len0_no_req", 32'(req_seen), 32'd0);
        chk("len0_done_cyc", 32'(done_cyc - cyc0), 32'd1);
        chk("len0_sum", done_sum, 32'd0);

        // spurious r_valid in IDLE
        sum0 = checksum;
        spur_cnt++;
        repeat (3) @(negedge clk);
        chk("spur_err_set", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        chk("spur_err_sticky", 32'(err), 32'd1);
        chk("spur_sum_unchanged", checksum, sum0);
        d0 = done_cnt;
        do_start(1'b1, 32'h0, 32'h0016_0000, 16'd3, 32'hFFFF_FFFF);
        chk("spur_err_cleared", 32'(err), 32'd0);
        wait_done("fill3", d0, 100);

        // reset in the middle of a COPY
        for (int i = 0; i < 8; i++) mem[32'h0017_0000 + 32'(i) * 4] = $urandom;
        d0 = done_cnt;
        do_start(1'b0, 32'h0017_0000, 32'h0018_0000, 16'd8, 32'h0);
        n = 0;
        while (wr_cnt < 3 && n < 200) begin @(negedge clk); n++; end
        chk("rst_mid_reached_3", 32'(wr_cnt >= 3), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(req), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_checksum", checksum, 0);
        chk("rstmid_add_data", add | wdata | 32'(be) | 32'(wen) | 32'(err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt;
        do_start(1'b0, 32'h0017_0000, 32'h0019_0000, 16'd8, 32'h0);
        wait_done("copy_after_rst", d0, 200);

        // randomized transfers, including unaligned inputs and address wrap
        gnt_rand = 1; lat_rand = 1;
        for (int t = 0; t < 6; t++) begin
            m = 1'($urandom_range(0, 1));
            l = 16'($urandom_range(1, 24));
            s = 32'h1000_0000 + (32'($urandom_range(0, 255)) << 8) + 32'($urandom_range(0, 3));
            d = (t == 2) ? 32'hFFFF_FFF2 : 32'h2000_0000 + (32'($urandom_range(0, 255)) << 8) + 32'($urandom_range(0, 3));
            for (int i = 0; i < int'(l); i++) mem[{s[31:2], 2'b00} + 32'(i) * 4] = $urandom;
            d0 = done_cnt;
            do_start(m, s, d, l, $urandom);
            wait_done("rand", d0, 2000);
            if (!m) chk("rand_occ_le_depth", 32'(max_occ <= 4), 32'd1);
        end

        // maximum length FILL
        gnt_rand = 0; lat_rand = 0;
        d0 = done_cnt;
        do_start(1'b1, 32'h0, 32'h3000_0000, 16'hFFFF, 32'hFFFF_FF00);
        wait_done("fill_max", d0, 70000);
        chk("fill_max_writes", 32'(wr_cnt), 32'd65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
